// File: rtl/seatbelt_pkg.sv
// Shared definitions for the seatbelt warning controller and its seconds helpers.
//   SEC_W      width of the seconds value and of the elapsed-seconds counter
//   state_t    2-bit FSM state code, exported on state_o
//   ST_*       state encodings
package seatbelt_pkg;

  localparam int unsigned SEC_W = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_GRACE   = 2'd1;
  localparam state_t ST_ALARM   = 2'd2;
  localparam state_t ST_TIMEOUT = 2'd3;

  localparam logic [SEC_W-1:0] SEC_MAX = {SEC_W{1'b1}};

endpackage

// File: rtl/sec_tick_detect.sv
// One-second tick derived from changes of the seconds value.
//   clk_i     system clock
//   rst_ni    asynchronous active-low reset
//   second_i  seconds value (0..59) from the seconds counter
//   tick_o    one-cycle pulse in every cycle where second_i differs from the
//             previous cycle's value; suppressed in the first cycle after reset
module sec_tick_detect
  import seatbelt_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [SEC_W-1:0] second_i,
  output logic             tick_o
);

  logic [SEC_W-1:0] sec_prev_q;
  logic             primed_q;

  // Previous-value register; primed masks the bogus edge against the reset value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sec_prev_q <= '0;
      primed_q   <= 1'b0;
    end else begin
      sec_prev_q <= second_i;
      primed_q   <= 1'b1;
    end
  end

  // Any change counts, so the 59->0 wrap is a tick like any other.
  assign tick_o = primed_q & (second_i != sec_prev_q);

endmodule

// File: rtl/seatbelt_alarm_fsm.sv
// Seatbelt warning controller: grace period, timed blinking alarm, silent timeout.
//   clk_i       system clock
//   rst_ni      asynchronous active-low reset
//   second_i    seconds value (0..59) from the seconds counter
//   ignition_i  ignition on
//   seat_i      seat occupied
//   belt_i      belt buckled
//   alarm_o     buzzer drive
//   led_o       warning lamp
//   state_o     current state (0 IDLE, 1 GRACE, 2 ALARM, 3 TIMEOUT)
//   elapsed_o   whole seconds elapsed in the current state
module seatbelt_alarm_fsm
  import seatbelt_pkg::*;
#(
  parameter int unsigned GRACE_S = 5,
  parameter int unsigned ALARM_S = 30
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [SEC_W-1:0] second_i,
  input  logic             ignition_i,
  input  logic             seat_i,
  input  logic             belt_i,
  output logic             alarm_o,
  output logic             led_o,
  output logic [1:0]       state_o,
  output logic [SEC_W-1:0] elapsed_o
);

  // A zero duration has no meaningful last second to compare against.
  if (GRACE_S == 0) begin : g_bad_grace
    $error("seatbelt_alarm_fsm: GRACE_S must be at least 1");
  end
  if (ALARM_S == 0) begin : g_bad_alarm
    $error("seatbelt_alarm_fsm: ALARM_S must be at least 1");
  end

  // Last elapsed value of each timed state, truncated to the counter width.
  localparam logic [SEC_W-1:0] GRACE_LAST = SEC_W'(GRACE_S - 1);
  localparam logic [SEC_W-1:0] ALARM_LAST = SEC_W'(ALARM_S - 1);

  state_t           state_q,   state_d;
  logic [SEC_W-1:0] elapsed_q, elapsed_d;
  logic             phase_q,   phase_d;
  logic             tick;
  logic             armed;

  sec_tick_detect u_tick (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .second_i (second_i),
    .tick_o   (tick)
  );

  assign armed = ignition_i & seat_i & ~belt_i;

  // State, elapsed counter and blink phase registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      elapsed_q <= '0;
      phase_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      elapsed_q <= elapsed_d;
      phase_q   <= phase_d;
    end
  end

  // Next-state logic; disarming overrides ticks and all other transitions.
  always_comb begin
    state_d   = state_q;
    elapsed_d = elapsed_q;
    phase_d   = phase_q;
    if (!armed) begin
      state_d   = ST_IDLE;
      elapsed_d = '0;
      phase_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d   = ST_GRACE;
          elapsed_d = '0;
        end
        ST_GRACE: begin
          if (tick) begin
            if (elapsed_q == GRACE_LAST) begin
              state_d   = ST_ALARM;
              elapsed_d = '0;
              phase_d   = 1'b1;
            end else begin
              elapsed_d = SEC_W'(elapsed_q + SEC_W'(1));
            end
          end
        end
        ST_ALARM: begin
          if (tick) begin
            if (elapsed_q == ALARM_LAST) begin
              state_d   = ST_TIMEOUT;
              elapsed_d = '0;
              phase_d   = 1'b0;
            end else begin
              elapsed_d = SEC_W'(elapsed_q + SEC_W'(1));
              phase_d   = ~phase_q;
            end
          end
        end
        ST_TIMEOUT: begin
          if (tick && (elapsed_q != SEC_MAX)) begin
            elapsed_d = SEC_W'(elapsed_q + SEC_W'(1));
          end
        end
        default: begin
          state_d   = ST_IDLE;
          elapsed_d = '0;
          phase_d   = 1'b0;
        end
      endcase
    end
  end

  // Moore output decode from registers only.
  always_comb begin
    alarm_o = 1'b0;
    led_o   = 1'b0;
    unique case (state_q)
      ST_IDLE:    led_o = 1'b0;
      ST_GRACE:   led_o = 1'b1;
      ST_ALARM: begin
        alarm_o = phase_q;
        led_o   = phase_q;
      end
      ST_TIMEOUT: led_o = 1'b1;
      default:    led_o = 1'b0;
    endcase
  end

  assign state_o   = state_q;
  assign elapsed_o = elapsed_q;

endmodule

// File: tb/tb_seatbelt_alarm_fsm.sv
module tb_seatbelt_alarm_fsm;

  logic       clk;
  logic       rst_n;
  logic [7:0] second;
  logic       ignition, seat, belt;
  logic       alarm, led, alarm1, led1;
  logic [1:0] state, state1;
  logic [7:0] elapsed, elapsed1;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0] st;
    logic       al;
    logic       led;
    logic [7:0] el;
  } exp_t;

  typedef struct {
    int   sec;
    bit   ign;
    bit   seat;
    bit   belt;
    exp_t e;
  } vec_t;

  exp_t sb_q[$];
  exp_t sb1_q[$];
  vec_t tbl[$];

  seatbelt_alarm_fsm #(.GRACE_S(5), .ALARM_S(30)) dut (
    .clk_i(clk), .rst_ni(rst_n), .second_i(second),
    .ignition_i(ignition), .seat_i(seat), .belt_i(belt),
    .alarm_o(alarm), .led_o(led), .state_o(state), .elapsed_o(elapsed)
  );

  seatbelt_alarm_fsm #(.GRACE_S(1), .ALARM_S(30)) dut_g1 (
    .clk_i(clk), .rst_ni(rst_n), .second_i(second),
    .ignition_i(ignition), .seat_i(seat), .belt_i(belt),
    .alarm_o(alarm1), .led_o(led1), .state_o(state1), .elapsed_o(elapsed1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk_e(int st, int al, int ld, int el);
    exp_t e;
    e.st  = 2'(st);
    e.al  = 1'(al);
    e.led = 1'(ld);
    e.el  = 8'(el);
    return e;
  endfunction

  function automatic vec_t mk_v(int s, int ig, int se, int be, int st, int al, int ld, int el);
    vec_t v;
    v.sec = s; v.ign = 1'(ig); v.seat = 1'(se); v.belt = 1'(be);
    v.e = mk_e(st, al, ld, el);
    return v;
  endfunction

  task automatic cmp(string name, exp_t got, exp_t e);
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL %s: got st=%0d al=%0d led=%0d el=%0d, expected st=%0d al=%0d led=%0d el=%0d",
               name, got.st, got.al, got.led, got.el, e.st, e.al, e.led, e.el);
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, compare after the edge.
  task automatic step(string name, vec_t v);
    exp_t e;
    second = 8'(v.sec); ignition = v.ign; seat = v.seat; belt = v.belt;
    sb_q.push_back(v.e);
    @(posedge clk); #1;
    e = sb_q.pop_front();
    cmp(name, {state, alarm, led, elapsed}, e);
  endtask

  task automatic step_both(string name, vec_t v, exp_t e1);
    exp_t e;
    sb1_q.push_back(e1);
    step(name, v);
    e = sb1_q.pop_front();
    cmp({name, "_g1"}, {state1, alarm1, led1, elapsed1}, e);
  endtask

  // Arm from IDLE at second 'start', then nk ticks; expectations from elapsed ticks since arming.
  task automatic run_arm(string name, int start, int nk);
    int e;
    step({name, "_idle"}, mk_v(start, 1, 1, 1, 0, 0, 0, 0));
    step({name, "_arm"},  mk_v(start, 1, 1, 0, 1, 0, 1, 0));
    for (int k = 1; k <= nk; k++) begin
      if (k < 5)       step({name, "_grace"}, mk_v((start + k) % 60, 1, 1, 0, 1, 0, 1, k));
      else if (k < 35) begin
        e = k - 5;
        step({name, "_alarm"}, mk_v((start + k) % 60, 1, 1, 0, 2, (e % 2 == 0), (e % 2 == 0), e));
      end else         step({name, "_tmo"}, mk_v((start + k) % 60, 1, 1, 0, 3, 0, 1, k - 35));
    end
  endtask

  initial begin
    int e;
    rst_n = 1'b0; second = 8'd0; ignition = 1'b1; seat = 1'b1; belt = 1'b1;
    #2;
    cmp("reset_state", {state, alarm, led, elapsed}, mk_e(0, 0, 0, 0));
    step("reset_hold", mk_v(0, 1, 1, 1, 0, 0, 0, 0));
    step("reset_hold", mk_v(0, 1, 1, 1, 0, 0, 0, 0));
    rst_n = 1'b1;

    // Buckled: 60 ticks, never leaves IDLE.
    for (int s = 1; s <= 60; s++) step("buckled", mk_v(s % 60, 1, 1, 1, 0, 0, 0, 0));

    // Unbuckle at second 10, grace, alarm entry and first toggles.
    tbl.push_back(mk_v(10, 1, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk_v(10, 1, 1, 0, 1, 0, 1, 0));
    tbl.push_back(mk_v(11, 1, 1, 0, 1, 0, 1, 1));
    tbl.push_back(mk_v(12, 1, 1, 0, 1, 0, 1, 2));
    tbl.push_back(mk_v(13, 1, 1, 0, 1, 0, 1, 3));
    tbl.push_back(mk_v(14, 1, 1, 0, 1, 0, 1, 4));
    tbl.push_back(mk_v(15, 1, 1, 0, 2, 1, 1, 0));
    tbl.push_back(mk_v(16, 1, 1, 0, 2, 0, 0, 1));
    tbl.push_back(mk_v(17, 1, 1, 0, 2, 1, 1, 2));
    foreach (tbl[i]) step("tbl_grace_alarm", tbl[i]);

    for (int s = 18; s <= 44; s++) begin
      e = s - 15;
      step("alarm_run", mk_v(s, 1, 1, 0, 2, (e % 2 == 0), (e % 2 == 0), e));
    end
    step("timeout_entry", mk_v(45, 1, 1, 0, 3, 0, 1, 0));

    // TIMEOUT counts ticks and saturates at 255.
    for (int k = 1; k <= 300; k++)
      step("timeout_sat", mk_v((45 + k) % 60, 1, 1, 0, 3, 0, 1, (k > 255) ? 255 : k));

    // Buckle without tick, then re-arm at 40 so ALARM spans the 59->0 wrap.
    step("buckle_idle", mk_v(45, 1, 1, 1, 0, 0, 0, 0));
    run_arm("wrap", 40, 35);
    step("buckle_idle2", mk_v(15, 1, 1, 1, 0, 0, 0, 0));

    // Belt buckled on a tick in ALARM, then ignition/seat drops with ticks.
    run_arm("pre_cancel", 20, 8);
    tbl.delete();
    tbl.push_back(mk_v(29, 1, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk_v(29, 1, 1, 0, 1, 0, 1, 0));
    tbl.push_back(mk_v(30, 1, 1, 0, 1, 0, 1, 1));
    tbl.push_back(mk_v(31, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk_v(31, 1, 1, 0, 1, 0, 1, 0));
    tbl.push_back(mk_v(32, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk_v(32, 1, 1, 0, 1, 0, 1, 0));
    tbl.push_back(mk_v(33, 1, 1, 0, 1, 0, 1, 1));
    foreach (tbl[i]) step("tbl_cancel", tbl[i]);

    // Asynchronous reset mid-ALARM, release with second 42.
    run_arm("pre_reset", 30, 7);
    #1 rst_n = 1'b0;
    #1 cmp("async_reset", {state, alarm, led, elapsed}, mk_e(0, 0, 0, 0));
    step("in_reset", mk_v(42, 1, 1, 0, 0, 0, 0, 0));
    step("in_reset", mk_v(42, 1, 1, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    step("release", mk_v(42, 1, 1, 0, 1, 0, 1, 0));
    step("release_hold", mk_v(42, 1, 1, 0, 1, 0, 1, 0));
    step("first_tick", mk_v(43, 1, 1, 0, 1, 0, 1, 1));

    // Seconds value held: no extra ticks.
    for (int i = 0; i < 1000; i++) step("hold_sec", mk_v(43, 1, 1, 0, 1, 0, 1, 1));
    step("after_hold", mk_v(44, 1, 1, 0, 1, 0, 1, 2));

    // GRACE_S=1: alarm on the first tick after entering GRACE.
    step_both("g1_idle",  mk_v(44, 1, 1, 1, 0, 0, 0, 0), mk_e(0, 0, 0, 0));
    step_both("g1_arm",   mk_v(44, 1, 1, 0, 1, 0, 1, 0), mk_e(1, 0, 1, 0));
    step_both("g1_alarm", mk_v(45, 1, 1, 0, 1, 0, 1, 1), mk_e(2, 1, 1, 0));
    step_both("g1_blink", mk_v(46, 1, 1, 0, 1, 0, 1, 2), mk_e(2, 0, 0, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
